// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_pkg
// Brief    : Shared types and default sizes for the self-clearing sync RAM.
// Revision : 1.0 - initial release
// ============================================================================
package ram_pkg;

    localparam int c_DEF_DATA_W = 32;
    localparam int c_DEF_ADDR_W = 5;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage : ram_pkg
`default_nettype wire

// File: rtl/ram_clr_fsm.sv
`default_nettype none
// ============================================================================
// Module   : ram_clr_fsm
// Brief    : Clear sequencer; walks every address once, emitting a zero-write strobe.
// Revision : 1.0 - initial release
// ============================================================================
module ram_clr_fsm
    import ram_pkg::*;
#(
    parameter int ADDR_W = c_DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = '1;

    clr_state_t        r_state;
    clr_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The counter stops on the last address so a clear never wraps into a second pass.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (clr) begin
                    w_state_nxt = CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                if (r_cnt == c_LAST_ADDR) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign busy     = (r_state == CLEAR);
    assign clr_we   = (r_state == CLEAR);
    assign clr_addr = r_cnt;

endmodule : ram_clr_fsm
`default_nettype wire

// File: rtl/ram_sync_clr.sv
`default_nettype none
// ============================================================================
// Module   : ram_sync_clr
// Brief    : Single-port sync RAM with byte enables and a sequenced whole-array clear.
// Revision : 1.0 - initial release
// ============================================================================
module ram_sync_clr
    import ram_pkg::*;
#(
    parameter int DATA_W = c_DEF_DATA_W,
    parameter int ADDR_W = c_DEF_ADDR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cen,
    input  logic                wen,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   din,
    input  logic [DATA_W/8-1:0] be,
    input  logic                clr,
    output logic                busy,
    output logic [DATA_W-1:0]   dout,
    output logic                dout_valid
);

    localparam int c_DEPTH = 2 ** ADDR_W;
    localparam int c_LANES = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic [DATA_W-1:0] r_dout;
    logic              r_dout_valid;

    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_idle_access;
    logic              w_user_wr;
    logic              w_user_rd;
    logic [DATA_W-1:0] w_be_mask;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;
    logic [DATA_W-1:0] w_wr_mask;

    ram_clr_fsm #(
        .ADDR_W   (ADDR_W)
    ) u_clr_fsm (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .busy     (w_busy),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr)
    );

    generate
        for (genvar gi = 0; gi < c_LANES; gi++) begin : g_be_mask
            assign w_be_mask[8*gi +: 8] = {8{be[gi]}};
        end
    endgenerate

    // A clr request in IDLE swallows any access presented alongside it.
    assign w_idle_access = !reset && !w_busy && !clr && cen;
    assign w_user_wr     = w_idle_access && wen;
    assign w_user_rd     = w_idle_access && !wen;

    // Clear path overrides the user path into the single storage write port.
    assign w_wr_en   = (w_clr_we && !reset) || w_user_wr;
    assign w_wr_addr = w_clr_we ? w_clr_addr : addr;
    assign w_wr_data = w_clr_we ? '0 : din;
    assign w_wr_mask = w_clr_we ? '1 : w_be_mask;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= (r_mem[w_wr_addr] & ~w_wr_mask) | (w_wr_data & w_wr_mask);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else if (w_user_rd) begin
            r_dout       <= r_mem[addr];
            r_dout_valid <= 1'b1;
        end else begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end
    end

    assign busy       = w_busy;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;

endmodule : ram_sync_clr
`default_nettype wire

// File: doc/ram_sync_clr.md
RAM_SYNC_CLR -- requirements
Module: ram_sync_clr

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W words.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port cen  input  1  chip enable; no access when 0.
REQ-006 Port wen  input  1  write enable; with cen=1: 1 = write, 0 = read.
REQ-007 Port addr  input  ADDR_W  word address.
REQ-008 Port din  input  DATA_W  write data.
REQ-009 Port be  input  DATA_W/8  byte-lane write enables; be[i] gates din[8i+7:8i].
REQ-010 Port clr  input  1  one-cycle request to zero the whole array.
REQ-011 Port busy  output  1  high while a clear sequence runs.
REQ-012 Port dout  output  DATA_W  registered read data.
REQ-013 Port dout_valid  output  1  high in the cycle dout carries read data.

Function
REQ-014 The block SHALL use a two-state FSM: IDLE and CLEAR.
REQ-015 In CLEAR, the block SHALL write all-zero data to address clr_cnt each cycle, starting at 0 and incrementing by 1.
REQ-016 The block SHALL leave CLEAR for IDLE in the cycle after it writes address DEPTH-1; a full clear takes exactly DEPTH cycles.
REQ-017 busy SHALL be 1 exactly while the FSM is in CLEAR.
REQ-018 In IDLE, clr=1 SHALL move the FSM to CLEAR with clr_cnt=0 on the next edge; any access in that same cycle SHALL be ignored.
REQ-019 clr during CLEAR SHALL be ignored; the clear SHALL neither restart nor extend.
REQ-020 While busy=1, cen, wen, addr, din and be SHALL be ignored; no user write, dout=0, dout_valid=0.
REQ-021 Write (IDLE, cen=1, wen=1, clr=0): on the edge, the block SHALL update only the byte lanes with be[i]=1 at mem[addr].
REQ-022 be=0 during a write SHALL leave the memory unchanged.
REQ-023 Read (IDLE, cen=1, wen=0, clr=0): dout SHALL equal mem[addr] and dout_valid SHALL be 1 on the following cycle; read latency is 1.
REQ-024 A read in the cycle after a write to the same address SHALL return the newly written data.
REQ-025 In any cycle with no read (cen=0, a write, or busy), the next dout SHALL be 0 and dout_valid SHALL be 0.
REQ-026 Addresses SHALL cover 0..DEPTH-1 fully; clr_cnt SHALL be ADDR_W bits wide and SHALL NOT wrap into a second pass.

Reset
REQ-027 Reset=1 SHALL force the FSM to CLEAR with clr_cnt=0, busy=1, dout=0 and dout_valid=0 on the next edge.
REQ-028 After reset deasserts, the array SHALL be zeroed automatically; busy SHALL fall DEPTH cycles later.
REQ-029 Reset asserted mid-clear SHALL restart the clear from address 0.
REQ-030 Reset SHALL take priority over clr and over every access.

Structure
REQ-031 A shared package ram_pkg SHALL hold the FSM state type (IDLE, CLEAR) and the DATA_W/ADDR_W defaults.
REQ-032 The FSM and clr_cnt SHALL live in one sub-module, ram_clr_fsm; its outputs SHALL be busy, the clear write strobe and the clear address.
REQ-033 The top level SHALL mux the clear address and zero data over the user write path into the storage array.

Verification
REQ-034 Reset for 1 cycle, then idle -> busy=1 for exactly 32 cycles; reading addresses 0..31 afterwards returns 0 with dout_valid=1.
REQ-035 Write addresses 0x01..0x1f with data = address and be=4'hF, then read them back -> dout = address one cycle after each read; with cen=0, dout=0 and dout_valid=0.
REQ-036 Write 32'hAABBCCDD to addr 3 with be=4'hF, then 32'h11223344 with be=4'b0101 -> reading addr 3 returns 32'hAA22CC44.
REQ-037 Write 32'h5 to addr 7, pulse clr, and attempt writes/reads while busy -> accesses ignored; after 32 cycles addr 7 reads 0.
REQ-038 Assert reset at clear cycle 10 -> busy stays 1 and clears for a further 32 cycles from address 0.
REQ-039 Write addr 9 = 32'h9, then read addr 9 in the next cycle -> dout = 32'h9, dout_valid=1.
